// File: rtl/dest_drain_arbiter.sv
// dest_drain_arbiter
// Drains the D0/D1 destination FIFOs with round-robin pops, buffers the
// returned words in a 4-entry tagged queue and presents one merged
// ready/valid stream. Also reports INIT/IDLE/ACTIVE status.
// Optional feature: define DRAIN_COUNTERS_EN to build the per-destination
// delivered-word counters; otherwise cnt_D0/cnt_D1 are tied to 0.

module dest_drain_arbiter #(
    parameter int DATA_WIDTH = 6,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic                  empty_fifo_D0,
    input  logic                  empty_fifo_D1,
    input  logic [DATA_WIDTH-1:0] data_out_D0,
    input  logic [DATA_WIDTH-1:0] data_out_D1,
    input  logic                  ready_in,
    output logic                  D0_pop,
    output logic                  D1_pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  dest_out,
    output logic                  idle_out,
    output logic                  active_out,
    output logic [CNT_WIDTH-1:0]  cnt_D0,
    output logic [CNT_WIDTH-1:0]  cnt_D1
);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    state_t state;

    // Round-robin pointer: 0 = D0 granted last, 1 = D1 granted last
    logic last;

    // Pop in flight (FIFO consumes it at the next edge) and its source
    logic pop_q;
    logic pop_sel;

    // Word arriving on data_out_Dx this cycle and its source
    logic cap_q;
    logic cap_sel;

    // Output queue storage
    logic [DATA_WIDTH-1:0] q_data [4];
    logic [3:0]            q_dest;
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic [2:0]            count;
    logic [1:0]            head_idx;

    logic [2:0] credit;
    logic       room;
    logic       elig0;
    logic       elig1;
    logic       grant0;
    logic       grant1;
    logic       enq;
    logic       deq;
    logic       pending;
    logic       any_data;

    // The pop strobes are themselves the "pop issued" record
    assign pop_q   = D0_pop | D1_pop;
    assign pop_sel = D1_pop;

    // Credit counts queued words plus everything still in the pipeline;
    // the same-cycle dequeue is deliberately ignored, so the queue cannot overflow
    assign credit = count + {2'b00, pop_q} + {2'b00, cap_q};
    assign room   = (credit < 3'd4);

    // A FIFO is never popped twice in a row because its empty flag lags the pop
    assign elig0  = init & ~empty_fifo_D0 & ~D0_pop & room;
    assign elig1  = init & ~empty_fifo_D1 & ~D1_pop & room;
    assign grant0 = elig0 & (~elig1 | last);
    assign grant1 = elig1 & (~elig0 | ~last);

    assign enq       = cap_q;
    assign valid_out = (count != 3'd0);
    assign deq       = valid_out & ready_in;

    // With an empty queue the slot behind rd_ptr still holds the last word shown
    assign head_idx = (count == 3'd0) ? (rd_ptr - 2'd1) : rd_ptr;
    assign data_out = q_data[head_idx];
    assign dest_out = q_dest[head_idx];

    assign pending  = pop_q | cap_q | (count != 3'd0);
    assign any_data = ~empty_fifo_D0 | ~empty_fifo_D1;

    // Register the arbitration result as the pop strobes and advance the round-robin pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            D0_pop <= 1'b0;
            D1_pop <= 1'b0;
            last   <= 1'b1;
        end else begin
            D0_pop <= grant0;
            D1_pop <= grant1;
            if (grant0 | grant1)
                last <= grant1;
        end
    end

    // Track that a popped word will be on the FIFO read port next cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_q   <= 1'b0;
            cap_sel <= 1'b0;
        end else begin
            cap_q   <= pop_q;
            cap_sel <= pop_sel;
        end
    end

    // Output queue: capture arriving words at the tail, retire the head on handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++)
                q_data[i] <= '0;
            q_dest <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                q_data[wr_ptr] <= cap_sel ? data_out_D1 : data_out_D0;
                q_dest[wr_ptr] <= cap_sel;
                wr_ptr         <= wr_ptr + 2'd1;
            end
            if (deq)
                rd_ptr <= rd_ptr + 2'd1;
            case ({enq, deq})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // Status state machine with registered idle/active flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_INIT;
            idle_out   <= 1'b0;
            active_out <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (init) begin
                        state      <= ST_IDLE;
                        idle_out   <= 1'b1;
                        active_out <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (!init) begin
                        state      <= ST_INIT;
                        idle_out   <= 1'b0;
                        active_out <= 1'b0;
                    end else if (any_data || pending) begin
                        state      <= ST_ACTIVE;
                        idle_out   <= 1'b0;
                        active_out <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (!init) begin
                        if (!pending) begin
                            state      <= ST_INIT;
                            idle_out   <= 1'b0;
                            active_out <= 1'b0;
                        end
                    end else if (!any_data && !pending) begin
                        state      <= ST_IDLE;
                        idle_out   <= 1'b1;
                        active_out <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_INIT;
                    idle_out   <= 1'b0;
                    active_out <= 1'b0;
                end
            endcase
        end
    end

`ifdef DRAIN_COUNTERS_EN
    // Count delivered words per destination, wrapping naturally
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_D0 <= '0;
            cnt_D1 <= '0;
        end else if (deq) begin
            if (dest_out)
                cnt_D1 <= cnt_D1 + CNT_WIDTH'(1);
            else
                cnt_D0 <= cnt_D0 + CNT_WIDTH'(1);
        end
    end
`else
    assign cnt_D0 = '0;
    assign cnt_D1 = '0;
`endif

endmodule

// File: tb/tb_dest_drain_arbiter.sv
// Testbench for dest_drain_arbiter: behavioural D0/D1 FIFOs, a scoreboard of
// hand-ordered expected words checked by a monitor on each handshake, and
// directed cycle-exact checks of pops, valid and status flags.

module tb_dest_drain_arbiter;

    localparam int DW = 6;
    localparam int CW = 8;

    logic          clk;
    logic          reset;
    logic          init;
    logic          empty_fifo_D0;
    logic          empty_fifo_D1;
    logic [DW-1:0] data_out_D0;
    logic [DW-1:0] data_out_D1;
    logic          ready_in;
    logic          D0_pop;
    logic          D1_pop;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          dest_out;
    logic          idle_out;
    logic          active_out;
    logic [CW-1:0] cnt_D0;
    logic [CW-1:0] cnt_D1;

    typedef struct packed {
        logic          dest;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] fifo0[$];
    logic [DW-1:0] fifo1[$];

    int pass_cnt;
    int total_cnt;

`ifdef DRAIN_COUNTERS_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    dest_drain_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .init          (init),
        .empty_fifo_D0 (empty_fifo_D0),
        .empty_fifo_D1 (empty_fifo_D1),
        .data_out_D0   (data_out_D0),
        .data_out_D1   (data_out_D1),
        .ready_in      (ready_in),
        .D0_pop        (D0_pop),
        .D1_pop        (D1_pop),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .dest_out      (dest_out),
        .idle_out      (idle_out),
        .active_out    (active_out),
        .cnt_D0        (cnt_D0),
        .cnt_D1        (cnt_D1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_cnt++;
        if (actual === expected)
            pass_cnt++;
        else
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    // Advance n clock cycles, ending 1 time unit after a rising edge
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Load words into the behavioural FIFOs
    task automatic apply_stimulus(input int n0, input int n1, input logic [DW-1:0] base0, input logic [DW-1:0] base1);
        for (int i = 0; i < n0; i++)
            fifo0.push_back(base0 + DW'(i));
        for (int i = 0; i < n1; i++)
            fifo1.push_back(base1 + DW'(i));
    endtask

    task automatic push_exp(input logic dest, input logic [DW-1:0] data);
        exp_t e;
        e.dest = dest;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        init     = 1'b0;
        ready_in = 1'b0;
        fifo0.delete();
        fifo1.delete();
        exp_q.delete();
        step(2);
        reset = 1'b1;
        step(1);
    endtask

    task automatic wait_drain(input int max_cycles);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || valid_out) && n < max_cycles) begin
            step(1);
            n++;
        end
        check_output("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        exp_t e;
        pass_cnt      = 0;
        total_cnt     = 0;
        reset         = 1'b1;
        init          = 1'b0;
        ready_in      = 1'b0;
        empty_fifo_D0 = 1'b1;
        empty_fifo_D1 = 1'b1;
        data_out_D0   = '0;
        data_out_D1   = '0;

        fork
            // FIFO model: a pop seen during a cycle is consumed by the next rising edge,
            // read data and empty flags update at the falling edge in between
            forever begin
                @(negedge clk);
                if (D0_pop && fifo0.size() != 0)
                    data_out_D0 = fifo0.pop_front();
                if (D1_pop && fifo1.size() != 0)
                    data_out_D1 = fifo1.pop_front();
                empty_fifo_D0 = (fifo0.size() == 0);
                empty_fifo_D1 = (fifo1.size() == 0);
            end
            // Monitor: every handshake must deliver the next expected word
            forever begin
                @(negedge clk);
                if (reset && valid_out && ready_in) begin
                    if (exp_q.size() == 0) begin
                        total_cnt++;
                        $display("[TB] FAIL sb_unexpected: got dest %0d data %0h, expected no word", dest_out, data_out);
                    end else begin
                        e = exp_q.pop_front();
                        check_output("sb_data", 32'(data_out), 32'(e.data));
                        check_output("sb_dest", 32'(dest_out), 32'(e.dest));
                    end
                end
            end
        join_none

        // Test 1: reset with init low while D0 holds 3 words
        #2 reset = 1'b0;
        apply_stimulus(3, 0, 6'h11, 6'h00);
        step(2);
        check_output("rst_valid", 32'(valid_out), 0);
        check_output("rst_data", 32'(data_out), 0);
        check_output("rst_pop", 32'(D0_pop | D1_pop), 0);
        check_output("rst_status", 32'({idle_out, active_out}), 0);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1);
            check_output("noinit_pop", 32'(D0_pop | D1_pop), 0);
            check_output("noinit_out", 32'({valid_out, data_out, idle_out, active_out}), 0);
        end
        ready_in = 1'b1;
        for (int i = 0; i < 3; i++)
            push_exp(1'b0, 6'h11 + DW'(i));
        init = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step(1);
            check_output("t1_pop", 32'(D0_pop), 32'(k < 5 && k % 2 == 0));
            check_output("t1_valid", 32'(valid_out), 32'(k == 2 || k == 4 || k == 6));
            if (k == 0)
                check_output("t1_idle", 32'(idle_out), 1);
            if (k == 1)
                check_output("t1_active", 32'(active_out), 1);
        end
        wait_drain(20);
        step(3);
        check_output("t1_end_idle", 32'({idle_out, active_out}), 32'(2'b10));
        check_output("t1_cnt0", 32'(cnt_D0), CNT_ON ? 3 : 0);

        // Test 2: both FIFOs hold 4 words, full throughput
        do_reset();
        init     = 1'b1;
        ready_in = 1'b1;
        step(2);
        apply_stimulus(4, 4, 6'h20, 6'h30);
        for (int i = 0; i < 4; i++) begin
            push_exp(1'b0, 6'h20 + DW'(i));
            push_exp(1'b1, 6'h30 + DW'(i));
        end
        for (int k = 0; k < 11; k++) begin
            step(1);
            check_output("t2_pop0", 32'(D0_pop), 32'(k < 8 && k % 2 == 0));
            check_output("t2_pop1", 32'(D1_pop), 32'(k < 8 && k % 2 == 1));
            check_output("t2_valid", 32'(valid_out), 32'(k >= 2 && k <= 9));
        end
        wait_drain(20);
        step(3);
        check_output("t2_cnt0", 32'(cnt_D0), CNT_ON ? 4 : 0);
        check_output("t2_cnt1", 32'(cnt_D1), CNT_ON ? 4 : 0);
        check_output("t2_idle", 32'({idle_out, active_out}), 32'(2'b10));

        // Test 3: backpressure stops pops after 4 credits are used
        do_reset();
        init = 1'b1;
        step(2);
        apply_stimulus(4, 4, 6'h08, 6'h18);
        for (int i = 0; i < 4; i++) begin
            push_exp(1'b0, 6'h08 + DW'(i));
            push_exp(1'b1, 6'h18 + DW'(i));
        end
        for (int k = 0; k < 8; k++) begin
            step(1);
            check_output("t3_pop0", 32'(D0_pop), 32'(k == 0 || k == 2));
            check_output("t3_pop1", 32'(D1_pop), 32'(k == 1 || k == 3));
            check_output("t3_valid", 32'(valid_out), 32'(k >= 2));
        end
        ready_in = 1'b1;
        wait_drain(60);
        step(3);
        check_output("t3_cnt0", 32'(cnt_D0), CNT_ON ? 4 : 0);
        check_output("t3_cnt1", 32'(cnt_D1), CNT_ON ? 4 : 0);

        // Test 4: init dropped with two pops in flight
        do_reset();
        init     = 1'b1;
        ready_in = 1'b1;
        step(2);
        apply_stimulus(4, 4, 6'h28, 6'h38);
        push_exp(1'b0, 6'h28);
        push_exp(1'b1, 6'h38);
        step(1);
        check_output("t4_pop0", 32'(D0_pop), 1);
        step(1);
        check_output("t4_pop1", 32'(D1_pop), 1);
        init = 1'b0;
        for (int k = 2; k < 9; k++) begin
            step(1);
            check_output("t4_nopop", 32'(D0_pop | D1_pop), 0);
            if (k == 2)
                check_output("t4_active", 32'(active_out), 1);
        end
        check_output("t4_init_state", 32'({idle_out, active_out}), 0);
        wait_drain(10);
        check_output("t4_cnt", 32'({cnt_D0, cnt_D1}), CNT_ON ? 32'(16'h0101) : 0);

        // Test 5: asynchronous reset mid-stream, arbitration restarts with D0
        do_reset();
        init     = 1'b1;
        ready_in = 1'b1;
        step(2);
        apply_stimulus(4, 4, 6'h2A, 6'h3A);
        step(3);
        check_output("t5_pre_pop0", 32'(D0_pop), 1);
        check_output("t5_pre_valid", 32'(valid_out), 1);
        reset = 1'b0;
        fifo0.delete();
        fifo1.delete();
        #1;
        check_output("t5_async_pop", 32'(D0_pop | D1_pop), 0);
        check_output("t5_async_valid", 32'(valid_out), 0);
        check_output("t5_async_data", 32'(data_out), 0);
        check_output("t5_async_status", 32'({idle_out, active_out}), 0);
        step(2);
        reset = 1'b1;
        apply_stimulus(1, 1, 6'h05, 6'h06);
        push_exp(1'b0, 6'h05);
        push_exp(1'b1, 6'h06);
        step(1);
        check_output("t5_restart_pop0", 32'({D0_pop, D1_pop}), 32'(2'b10));
        step(1);
        check_output("t5_restart_pop1", 32'({D0_pop, D1_pop}), 32'(2'b01));
        wait_drain(20);

        // Test 6: 257 D1 words wrap the 8-bit counter
        do_reset();
        init     = 1'b1;
        ready_in = 1'b1;
        step(2);
        apply_stimulus(0, 257, 6'h00, 6'h00);
        for (int i = 0; i < 257; i++)
            push_exp(1'b1, DW'(i));
        wait_drain(700);
        step(3);
        check_output("t6_cnt1", 32'(cnt_D1), CNT_ON ? 1 : 0);
        check_output("t6_cnt0", 32'(cnt_D0), 0);

        $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/dest_drain_arbiter.md
# dest_drain_arbiter

Downstream drain stage for the D0/D1 destination FIFOs of the transmit logic. It watches both FIFO empty flags, issues round-robin pops, captures the returned words into a 4-entry output queue, and presents one merged stream to the next layer with a ready/valid handshake. Each word carries a destination tag. The block also reports idle/active status.

## Interface
- DATA_WIDTH, 6, width of FIFO words and `data_out`
- CNT_WIDTH, 8, width of the per-destination word counters
---
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- init  in  1  drain enable; no new pops are issued while low
- empty_fifo_D0, empty_fifo_D1  in  1 each  FIFO empty flags
- data_out_D0, data_out_D1  in  DATA_WIDTH each  FIFO read data; valid the cycle after the edge that consumed a pop
- ready_in  in  1  downstream accepts the head word
- D0_pop, D1_pop  out  1 each  registered FIFO pop strobes; never both high
- data_out  out  DATA_WIDTH  head-of-queue word
- valid_out  out  1  `data_out` is valid
- dest_out  out  1  destination of the head word (0 = D0, 1 = D1)
- idle_out  out  1  high in IDLE
- active_out  out  1  high in ACTIVE
- cnt_D0, cnt_D1  out  CNT_WIDTH each  words delivered per destination

## Operation
- Pipeline of one pop:
  - Edge E0 registers the pop.
  - The FIFO consumes it at E1.
  - The block captures `data_out_Dx` at E2 into the queue tail, tagged x.
- Tracking registers:
  - `pop_q`, `pop_sel`: pop issued this cycle and which FIFO.
  - `cap_q`, `cap_sel`: word arriving this cycle and its source.
- Eligibility of Dx for a pop registered at the next edge requires all of:
  - `init` = 1
  - `empty_fifo_Dx` = 0
  - `Dx_pop` currently low. This blocks back-to-back pops on the same FIFO, because the empty flag lags the pop by one edge.
  - `count + pop_q + cap_q < 4`. This is a conservative credit check that ignores the same-cycle dequeue.
- Arbitration:
  - If both FIFOs are eligible, take the one not last granted. The `last` pointer resets to D1, so D0 wins first.
  - If only one is eligible, take it.
  - `last` updates only on a grant.
- Queue: 4 entries, FIFO order.
  - Dequeue occurs on `valid_out && ready_in`.
  - Enqueue and dequeue in the same edge leave `count` unchanged.
  - The head is shown on `data_out`/`dest_out`.
  - `valid_out` = (`count` != 0).
  - When `count` = 0, `data_out` and `dest_out` hold their last values.
- State machine (registered; `pending` = `pop_q | cap_q | (count != 0)`):
  - INIT: entered on reset. Go to IDLE when `init` = 1.
  - IDLE: go to ACTIVE when any FIFO is non-empty or `pending` is set. Go to INIT if `init` = 0.
  - ACTIVE: go to IDLE when both FIFOs are empty and `pending` = 0. If `init` = 0, stop issuing pops, finish in-flight captures and queued deliveries, then go to INIT when `pending` = 0.
- Counters: `cnt_Dx` increments on each handshake whose `dest_out` = x and wraps modulo 2^CNT_WIDTH.

## Timing
- Reset values:
  - All outputs 0.
  - `count`, `pop_q`, `cap_q` = 0.
  - State = INIT, `last` = D1.
- Reset is asynchronous. Asserting it mid-operation discards in-flight pops and queued words. Upstream FIFOs are reset together with this block.
- Latency:
  - Both FIFOs are sampled at edge E0.
  - Pop is high during E0→E1.
  - `valid_out` rises after E2, so first data appears 2 cycles after the pop.
- Throughput with `ready_in` = 1:
  - 1 word/cycle when both FIFOs hold data (alternating D0/D1).
  - 1 word per 2 cycles when only one FIFO holds data.
- Backpressure: with `ready_in` = 0, pops stop once `count + pop_q + cap_q` = 4. The queue never overflows.
- `idle_out` and `active_out` are registered and mutually exclusive. Both are low in INIT.

## Configuration
- `DRAIN_COUNTERS_EN` defined: `cnt_D0` and `cnt_D1` are implemented as described.
- `DRAIN_COUNTERS_EN` undefined: the ports remain, tied to 0, and no counter flops are built.

## Test plan
- Reset with `init` = 0 while D0 holds 3 words:
  - No pops are issued.
  - All outputs stay 0.
  - Raising `init` makes `D0_pop` pulse on alternate cycles.
  - Words appear in order, 2 cycles after each pop, with `dest_out` = 0.
- Both FIFOs hold 4 words each, `ready_in` = 1:
  - Pops alternate D0, D1, … starting with D0.
  - `valid_out` stays high for 8 consecutive cycles.
  - `dest_out` alternates 0,1,…
  - `cnt_D0` = `cnt_D1` = 4, then IDLE.
- Backpressure: `ready_in` = 0, both FIFOs hold 4 words:
  - Exactly 4 pops are issued, then pops stop.
  - Raising `ready_in` drains the queue in order and pops resume.
- `init` dropped in ACTIVE with 2 pops in flight:
  - Those 2 words are still delivered.
  - No further pops are issued.
  - State reaches INIT.
- `reset` asserted mid-stream:
  - Outputs go to 0 immediately (asynchronously).
  - After release, arbitration restarts with D0.
- Counter wrap, build with `DRAIN_COUNTERS_EN` and CNT_WIDTH = 8:
  - 257 D1 words give `cnt_D1` = 1.
  - In a build without the macro, both counters read 0.
